rf_sweep: RTL and testbench
===========================

# rf_sweep

Parametrised register file with synchronous sweep-clear and optional write-to-read forwarding. It is the successor to the CPU's fixed 32×32 register file. It sits in the decode stage: two registered read ports feed operand latches, and one write port is driven from writeback. Its contents are cleared by a hardware sweep after reset, not by simulation-only initialisation.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register-number width
- DEPTH, 32, implemented entries; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- regwr  in  1  write enable
- wr  in  ADDR_W  write register number
- wd  in  DATA_W  write data
- rr1  in  ADDR_W  read register number, port 1
- rr2  in  ADDR_W  read register number, port 2
- rd1  out  DATA_W  registered read data, port 1
- rd2  out  DATA_W  registered read data, port 2
- ready  out  1  high when the clear sweep is complete and the file accepts writes

## Operation
- FSM states are CLEAR and RUN. Storage is DEPTH×DATA_W plus a clear pointer `ptr` of width ADDR_W.
- rst high at an edge:
  - state←CLEAR, ptr←0, ready←0, rd1←0, rd2←0.
  - Storage is not touched.
  - Holding rst high keeps the block in this condition.
- CLEAR, rst low, at each edge:
  - mem[ptr]←0.
  - If ptr==DEPTH−1: state←RUN and ready←1. Otherwise ptr←ptr+1.
  - regwr is ignored.
  - rd1 and rd2 are loaded with 0.
- RUN, at each edge:
  - rd1←read(rr1) and rd2←read(rr2).
  - Then, if regwr and the write is valid, mem[wr]←wd.
- read(a) returns 0 when a ≥ DEPTH, or when ZERO_REG=1 and a==0. Otherwise it returns mem[a]. Same-address forwarding is covered under Configuration.
- A write is valid when wr < DEPTH and not (ZERO_REG=1 and wr==0). Invalid writes are silently dropped.
- Both read ports are independent. rr1==rr2 is legal, and both ports return the same value.
- rst asserted mid-sweep restarts the sweep from entry 0.
- rst asserted in RUN discards any write presented at that edge.

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on rd1/rd2 after edge N and holds until the next edge.
- Write latency is 1 cycle: data written at edge N is visible to a read sampled at edge N+1.
- Same-edge read and write to one address: the result depends on the macro (see Configuration).
- Sweep duration is exactly DEPTH edges with rst low. With the first low-rst edge counted as edge 1, ready is high after edge DEPTH, and the first write is accepted at edge DEPTH+1.
- Reset values: rd1=0, rd2=0, ready=0. `ptr` is 0 and state is CLEAR.
- There are no combinational paths from inputs to outputs.

## Configuration
- Macro RF_BYPASS_EN controls same-edge forwarding.
- With RF_BYPASS_EN defined, in RUN: if regwr, the write is valid, and rrX==wr, then rdX←wd. This is write-first behaviour.
- Without it, rdX←the old mem[rrX]. This is read-first behaviour and matches the previous register file.
- The macro does not affect reads of entry 0 under ZERO_REG=1, or of addresses ≥ DEPTH. These reads always return 0.

## Test plan
- **Sweep.** Use defaults. Hold rst high for 3 cycles, then release. Required response:
  - ready=0 for edges 1–31 and goes to 1 after edge 32.
  - Reading r5 and r31 afterwards returns 0.
  - A write of 0xDEAD to r3 presented at edge 10 is dropped; r3 reads 0.
- **Write/read.** After ready, write 0x0123 to r2, then set rr1=2 and rr2=2 on the next edge. Required response: rd1=rd2=0x0123 one cycle later.
- **Same-edge collision.** r7 holds 0x11. At one edge, write 0x22 to r7 with rr1=7. Required response:
  - rd1=0x22 when RF_BYPASS_EN is defined.
  - rd1=0x11 when it is not.
  - On the next edge, rd1=0x22 in both builds.
- **Zero register.** With ZERO_REG=1, write 0xFFFFFFFF to r0 with rr1=0 at the same edge, then read r0 again. Required response: rd1=0 on both reads, in both builds.
- **Out-of-range.** Use DEPTH=20. Write 0x55 to r25, then read r25. Required response: rd1=0, and r5 is unchanged.
- **Reset mid-sweep.** Assert rst for 1 cycle at sweep edge 15. Required response:
  - ready stays 0 and rises 32 edges after rst falls.
  - A value written to r20 before the reset reads 0 once ready is high.

Source files
------------

// File: rtl/rf_sweep.sv
// rf_sweep: parametrised register file with a hardware clear sweep after reset.
//
// Ports:
//   clk    - single clock; all state updates on its rising edge
//   rst    - synchronous, active-high reset
//   regwr  - write enable (ignored while the clear sweep runs)
//   wr     - write register number
//   wd     - write data
//   rr1    - read register number, port 1
//   rr2    - read register number, port 2
//   rd1    - registered read data, port 1 (one-cycle latency)
//   rd2    - registered read data, port 2 (one-cycle latency)
//   ready  - high once the sweep has cleared every entry
//
// Configuration macro:
//   RF_BYPASS_EN - when defined, a same-edge write to the addressed register is
//                  forwarded to the read port (write-first). When undefined,
//                  reads return the old contents (read-first).
//
// After reset the block spends exactly DEPTH edges writing zero into each
// entry in turn; only then does it accept writes and return stored data.
module rf_sweep #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwr,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_ok;

    // An address is backed by real storage: in range and not the hard-wired zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ready_d   = ready_q;
        rd1_d     = '0;
        rd2_d     = '0;
        mem_we    = 1'b0;
        mem_waddr = wr;
        mem_wdata = wd;
        wr_ok     = regwr && addr_ok(wr);

        if (state_q == ST_CLEAR) begin
            // Sweep owns the write port; external writes are ignored.
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
            if (ptr_q == LAST_PTR) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end else begin
            rd1_d = addr_ok(rr1) ? mem_q[rr1] : '0;
            rd2_d = addr_ok(rr2) ? mem_q[rr2] : '0;
`ifdef RF_BYPASS_EN
            // wr_ok already implies the shared address is real storage.
            if (wr_ok && (rr1 == wr)) rd1_d = wd;
            if (wr_ok && (rr2 == wr)) rd2_d = wd;
`endif
            mem_we = wr_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end

    // Storage has no reset; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd1   = rd1_q;
    assign rd2   = rd2_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_rf_sweep.sv
// Directed self-checking bench for rf_sweep: a default instance (DEPTH=32) and
// a DEPTH=20 instance share the stimulus.
module tb_rf_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        regwr = 1'b0;
    logic [4:0]  wr = '0;
    logic [31:0] wd = '0;
    logic [4:0]  rr1 = '0;
    logic [4:0]  rr2 = '0;
    logic [31:0] rd1, rd2, rd1_s, rd2_s;
    logic        ready, ready_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rf_sweep dut (
        .clk   (clk),
        .rst   (rst),
        .regwr (regwr),
        .wr    (wr),
        .wd    (wd),
        .rr1   (rr1),
        .rr2   (rr2),
        .rd1   (rd1),
        .rd2   (rd2),
        .ready (ready)
    );

    rf_sweep #(
        .DEPTH (20)
    ) dut_small (
        .clk   (clk),
        .rst   (rst),
        .regwr (regwr),
        .wr    (wr),
        .wd    (wd),
        .rr1   (rr1),
        .rr2   (rr2),
        .rd1   (rd1_s),
        .rd2   (rd2_s),
        .ready (ready_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_coll;

    initial begin
        // Reset held for three edges.
        rst = 1'b1;
        repeat (3) tick();
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        check("reset_ready", {31'b0, ready}, 32'h0);

        // Sweep; a write presented at edge 10 must be dropped.
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            regwr = (e == 10);
            wr    = 5'd3;
            wd    = 32'hDEAD;
            tick();
            check($sformatf("sweep_ready_e%0d", e), {31'b0, ready}, {31'b0, (e >= 32)});
            if (e == 19 || e == 20)
                check($sformatf("sweep20_ready_e%0d", e), {31'b0, ready_s},
                      {31'b0, (e >= 20)});
            if (e == 16) check("sweep_rd1_zero", rd1, 32'h0);
        end
        regwr = 1'b0;

        rr1 = 5'd5;
        rr2 = 5'd31;
        tick();
        check("cleared_r5", rd1, 32'h0);
        check("cleared_r31", rd2, 32'h0);
        rr1 = 5'd3;
        tick();
        check("dropped_r3", rd1, 32'h0);

        // Write then read on both ports.
        regwr = 1'b1; wr = 5'd2; wd = 32'h0123;
        tick();
        regwr = 1'b0; rr1 = 5'd2; rr2 = 5'd2;
        tick();
        check("wr_rd1_r2", rd1, 32'h0123);
        check("wr_rd2_r2", rd2, 32'h0123);

        // Same-edge collision on r7.
        rr1 = 5'd0;
        regwr = 1'b1; wr = 5'd7; wd = 32'h11;
        tick();
        wd = 32'h22; rr1 = 5'd7;
        tick();
`ifdef RF_BYPASS_EN
        exp_coll = 32'h22;
`else
        exp_coll = 32'h11;
`endif
        check("collision_r7", rd1, exp_coll);
        regwr = 1'b0;
        tick();
        check("after_collision_r7", rd1, 32'h22);

        // Zero register ignores writes, even same-edge.
        regwr = 1'b1; wr = 5'd0; wd = 32'hFFFF_FFFF; rr1 = 5'd0;
        tick();
        check("zero_same_edge", rd1, 32'h0);
        regwr = 1'b0;
        tick();
        check("zero_reread", rd1, 32'h0);

        // Out-of-range on the DEPTH=20 instance.
        regwr = 1'b1; wr = 5'd5; wd = 32'h77;
        tick();
        wr = 5'd25; wd = 32'h55;
        tick();
        regwr = 1'b0; rr1 = 5'd25;
        tick();
        check("oor_r25_small", rd1_s, 32'h0);
        check("inrange_r25_full", rd1, 32'h55);
        rr1 = 5'd5;
        tick();
        check("oor_r5_kept", rd1_s, 32'h77);

        // Reset mid-sweep restarts from entry 0 and clears r20 again.
        regwr = 1'b1; wr = 5'd20; wd = 32'hABCD;
        tick();
        regwr = 1'b0; rr1 = 5'd20;
        tick();
        check("r20_before_reset", rd1, 32'hABCD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        check("midsweep_rst_ready", {31'b0, ready}, 32'h0);
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e == 1 || e == 17 || e == 31 || e == 32)
                check($sformatf("resweep_ready_e%0d", e), {31'b0, ready}, {31'b0, (e >= 32)});
        end
        rr1 = 5'd20;
        tick();
        check("r20_after_resweep", rd1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
